div_unit: RTL and testbench

- Iterative RV32M divide unit in the EX stage; consumes the two register-file read operands (rs1 = dividend, rs2 = divisor) plus destination rd.
- Implements DIV, DIVU, REM and REMU with radix-2 restoring division at one quotient bit per cycle.
- Returns a single-cycle result strobe carrying rd address and write enable toward writeback / register-file write port.
- Drives busy_o so the pipeline controller can stall issue while a division is in flight.

---
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring, one quotient
// bit per cycle, with single-cycle fast path for divide-by-zero and signed overflow.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              last_reg;
  logic [XLEN-1:0]   rem_reg, quo_reg, dvs_reg;
  logic [4:0]        rd_reg;
  logic              rem_sel_reg, neg_quo_reg, neg_rem_reg;

  logic              accept, is_signed, div_zero, overflow, fast;
  logic [XLEN-1:0]   abs_dvd, abs_dvs, fast_result;
  logic [XLEN-1:0]   shift_low, diff, quo_fix, rem_fix;
  logic              borrow, trial_ok;

  assign accept    = (state_reg == IDLE) && start_i && !flush_i;
  assign is_signed = !op_i[0];
  assign div_zero  = (divisor_i == '0);
  assign overflow  = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);
  assign fast      = div_zero || overflow;

  assign abs_dvd = (is_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign abs_dvs = (is_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

  // Overflow quotient equals the dividend itself (0x80000000), remainder 0.
  assign fast_result = op_i[1] ? (div_zero ? dividend_i : '0)
                               : (div_zero ? '1 : dividend_i);

  // Shifted partial remainder is {rem_reg[MSB], shift_low}; a set top bit
  // guarantees the trial subtraction succeeds regardless of the borrow.
  assign shift_low       = {rem_reg[XLEN-2:0], quo_reg[XLEN-1]};
  assign {borrow, diff}  = {1'b0, shift_low} - {1'b0, dvs_reg};
  assign trial_ok        = rem_reg[XLEN-1] || !borrow;

  assign quo_fix = neg_quo_reg ? -quo_reg : quo_reg;
  assign rem_fix = neg_rem_reg ? -rem_reg : rem_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = fast ? DONE : CALC;
      CALC: begin
        if (flush_i)       state_next = IDLE;
        else if (last_reg) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_reg != IDLE);
    valid_o   = (state_reg == DONE) && !flush_i;
    reg_wen_o = valid_o && (rd_addr_o != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      last_reg    <= 1'b0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      rd_reg      <= '0;
      rem_sel_reg <= 1'b0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_o    <= '0;
      rd_addr_o   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rem_sel_reg <= op_i[1];
            rd_reg      <= rd_addr_i;
            neg_quo_reg <= is_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
            neg_rem_reg <= is_signed && dividend_i[XLEN-1];
            quo_reg     <= abs_dvd;
            dvs_reg     <= abs_dvs;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            last_reg    <= 1'b0;
            if (fast) begin
              result_o  <= fast_result;
              rd_addr_o <= rd_addr_i;
            end
          end
        end
        CALC: begin
          if (!flush_i) begin
            if (!last_reg) begin
              rem_reg <= trial_ok ? diff : shift_low;
              quo_reg <= {quo_reg[XLEN-2:0], trial_ok};
              cnt_reg <= cnt_reg + 1'b1;
              if (cnt_reg == CNT_W'(XLEN-1)) last_reg <= 1'b1;
            end else begin
              // Extra cycle after the last iteration applies sign correction.
              result_o  <= rem_sel_reg ? rem_fix : quo_fix;
              rd_addr_o <= rd_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, hand-written
// flush/reset/start-while-busy sequences, and randomized ops vs a reference model.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] dividend_i = 32'd0;
  logic [31:0] divisor_i = 32'd0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        busy_o, valid_o, reg_wen_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .reg_wen_o  (reg_wen_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!op[0]) begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // Present a request and return just after the edge that accepts it.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom; rd_addr_i = 5'($urandom);
  endtask

  // k counts negedges after the accepting edge; valid in the cycle right after edge T+n gives lat n.
  task automatic wait_valid(input int k0, output logic [31:0] res, output logic [4:0] rdo,
                            output logic wen, output int lat, output bit seen, output bit busy_ok);
    res = '0; rdo = '0; wen = 1'b0; lat = -1; seen = 1'b0; busy_ok = 1'b1;
    for (int k = k0; k < k0 + 60 && !seen; k++) begin
      @(negedge clk);
      if (!busy_o) busy_ok = 1'b0;
      if (valid_o) begin
        seen = 1'b1; res = result_o; rdo = rd_addr_o; wen = reg_wen_o; lat = k;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] exp, input logic [4:0] rd,
                              input int exp_lat, input int k0);
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        wen;
    int          lat;
    bit          seen, busy_ok;
    wait_valid(k0, res, rdo, wen, lat, seen, busy_ok);
    $display("[TB] %s rd=%0d -> result=0x%08h lat=%0d", name, rd, res, lat);
    check({name, " strobe"}, 32'(seen), 32'd1);
    check({name, " result"}, res, exp);
    check({name, " rd_addr"}, 32'(rdo), 32'(rd));
    check({name, " reg_wen"}, 32'(wen), 32'(rd != 5'd0));
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int exp_lat);
    issue(op, a, b, rd);
    check_result(name, exp, rd, exp_lat, 0);
    @(negedge clk);
    check({name, " idle_after"}, {30'd0, busy_o, valid_o}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, a, b;
    logic [4:0]  rdo, rd;
    logic [1:0]  op;
    logic        wen;
    int          lat, vcount;
    bit          seen, busy_ok;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33, "divu_100_7"};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          33, "remu_100_7"};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33, "div_m7_2"};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  33, "rem_m7_2"};
    vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd6,  32'd1,          33, "rem_7_m2"};
    vecs[5]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  33, "divu_max_1"};
    vecs[6]  = '{OP_DIV,  32'd1234,       32'd0,          5'd8,  32'hFFFF_FFFF,  0,  "div_by_zero"};
    vecs[7]  = '{OP_REMU, 32'd1234,       32'd0,          5'd9,  32'd1234,       0,  "remu_by_zero"};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  0,  "div_overflow"};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          0,  "rem_overflow"};
    vecs[10] = '{OP_DIVU, 32'd50,         32'd5,          5'd0,  32'd10,         33, "divu_rd0"};
    vecs[11] = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          5'd12, 32'hFFFF_FFF2,  33, "div_m100_7"};
    vecs[12] = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          5'd13, 32'hFFFF_FFFE,  33, "rem_m100_7"};
    vecs[13] = '{OP_DIV,  32'h8000_0000,  32'd1,          5'd14, 32'h8000_0000,  33, "div_min_1"};
    vecs[14] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  33, "remu_min_max"};

    // Reset state.
    #2;
    check("reset outputs", {22'd0, busy_o, valid_o, reg_wen_o, rd_addr_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Flush mid-calculation, then a fresh op.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd7);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    vcount = 0;
    @(negedge clk);
    check("flush calc busy", 32'(busy_o), 32'd0);
    for (int k = 0; k < 40; k++) begin
      if (valid_o) vcount++;
      @(negedge clk);
    end
    $display("[TB] flush_calc valid pulses=%0d", vcount);
    check("flush calc no strobe", 32'(vcount), 32'd0);
    do_op("divu_9_3_after_flush", OP_DIVU, 32'd9, 32'd3, 5'd2, 32'd3, 33);

    // Start re-pulsed with other operands during CALC must be ignored.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
    repeat (5) @(negedge clk);
    start_i = 1'b1; op_i = OP_REMU; dividend_i = 32'd500; divisor_i = 32'd2; rd_addr_i = 5'd1;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    check_result("restart_ignored", 32'd14, 5'd9, 33, 8);

    // Start during the DONE cycle is ignored, accepted the cycle after.
    issue(OP_DIVU, 32'd20, 32'd4, 5'd3);
    wait_valid(0, res, rdo, wen, lat, seen, busy_ok);
    $display("[TB] b2b_first -> result=0x%08h lat=%0d", res, lat);
    check("b2b first result", res, 32'd5);
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd3; rd_addr_i = 5'd17;
    @(negedge clk);
    check("b2b ignored in done", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1 start_i = 1'b0;
    check_result("b2b_second", 32'd3, 5'd17, 33, 0);

    // Flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd8; divisor_i = 32'd2;
    @(posedge clk);
    #1 start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    $display("[TB] flush_with_start busy=%0d", busy_o);
    check("flush with start", 32'(busy_o), 32'd0);

    // Flush in the DONE cycle suppresses the strobe combinationally.
    issue(OP_DIVU, 32'd77, 32'd7, 5'd21);
    wait_valid(0, res, rdo, wen, lat, seen, busy_ok);
    check("flush done reached", 32'(seen), 32'd1);
    flush_i = 1'b1;
    #1;
    $display("[TB] flush_done valid=%0d wen=%0d", valid_o, reg_wen_o);
    check("flush done valid", {30'd0, valid_o, reg_wen_o}, 32'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush done idle", 32'(busy_o), 32'd0);

    // Asynchronous reset in the middle of CALC.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd7);
    repeat (20) @(negedge clk);
    check("pre-reset busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    $display("[TB] reset_mid_calc busy=%0d valid=%0d result=0x%08h", busy_o, valid_o, result_o);
    check("reset mid busy/valid", {22'd0, busy_o, valid_o, reg_wen_o, rd_addr_o}, 32'd0);
    check("reset mid result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("div_after_reset", OP_DIV, 32'hFFFF_FC18, 32'd10, 5'd19, 32'hFFFF_FF9C, 33);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom) >> $urandom_range(0, 31);
      endcase
      rd = 5'($urandom);
      do_op($sformatf("rand%0d op%0d a=%08h b=%08h", i, op, a, b), op, a, b, rd,
            ref_div(op, a, b), ref_lat(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
